// File: rtl/msrv32_branch_predict_unit.sv
// Branch resolve unit with a bimodal predictor and hit/miss statistics.
// Ports: clk_in/rst_n_in; fetch lookup (fetch_pc_in -> predict_taken_out);
// resolve request (res_*, rs1/rs2, opcode/funct3) -> registered outcome;
// saturating branch_cnt_out and miss_cnt_out.
module msrv32_branch_predict_unit #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [XLEN-1:0]  fetch_pc_in,
    output logic             predict_taken_out,
    input  logic             res_valid_in,
    input  logic [XLEN-1:0]  res_pc_in,
    input  logic [XLEN-1:0]  rs1_in,
    input  logic [XLEN-1:0]  rs2_in,
    input  logic [4:0]       opcode_in,
    input  logic [2:0]       funct3_in,
    input  logic             res_pred_in,
    output logic             res_done_out,
    output logic             branch_taken_out,
    output logic             mispredict_out,
    output logic [CNT_W-1:0] branch_cnt_out,
    output logic [CNT_W-1:0] miss_cnt_out
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]          tbl_q [DEPTH];
    logic [IDX_BITS-1:0] fetch_idx;
    logic [IDX_BITS-1:0] res_idx;
    logic                is_branch;
    logic                is_jump;
    logic                is_cond;
    logic                cmp_taken;
    logic                outcome;
    logic                miss;

    assign fetch_idx = fetch_pc_in[IDX_BITS+1:2];
    assign res_idx   = res_pc_in[IDX_BITS+1:2];

    // No bypass: a same-cycle update is seen by fetch one cycle later.
    assign predict_taken_out = tbl_q[fetch_idx][1];

    assign is_branch = (opcode_in == 5'b11000);
    assign is_jump   = (opcode_in == 5'b11011) ||
                       (opcode_in == 5'b11001);
    // funct3 010/011 under BRANCH are not real branches.
    assign is_cond   = is_branch &&
                       (funct3_in != 3'b010) &&
                       (funct3_in != 3'b011);

    always_comb begin
        cmp_taken = 1'b0;
        case (funct3_in)
            3'b000:  cmp_taken = (rs1_in == rs2_in);
            3'b001:  cmp_taken = (rs1_in != rs2_in);
            3'b100:  cmp_taken = ($signed(rs1_in) < $signed(rs2_in));
            3'b101:  cmp_taken = ($signed(rs1_in) >= $signed(rs2_in));
            3'b110:  cmp_taken = (rs1_in < rs2_in);
            3'b111:  cmp_taken = (rs1_in >= rs2_in);
            default: cmp_taken = 1'b0;
        endcase
    end

    always_comb begin
        outcome = 1'b0;
        unique case (1'b1)
            is_jump: outcome = 1'b1;
            is_cond: outcome = cmp_taken;
            default: outcome = 1'b0;
        endcase
    end

    assign miss = outcome ^ res_pred_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= 2'b01;
            end
        end else if (res_valid_in && is_cond) begin
            if (outcome && tbl_q[res_idx] != 2'b11) begin
                tbl_q[res_idx] <= tbl_q[res_idx] + 2'd1;
            end else if (!outcome && tbl_q[res_idx] != 2'b00) begin
                tbl_q[res_idx] <= tbl_q[res_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_done_out     <= 1'b0;
            branch_taken_out <= 1'b0;
            mispredict_out   <= 1'b0;
            branch_cnt_out   <= '0;
            miss_cnt_out     <= '0;
        end else if (res_valid_in) begin
            res_done_out     <= 1'b1;
            branch_taken_out <= outcome;
            mispredict_out   <= miss;
            if (is_cond && branch_cnt_out != CNT_MAX) begin
                branch_cnt_out <= branch_cnt_out + 1'b1;
            end
            if (miss && miss_cnt_out != CNT_MAX) begin
                miss_cnt_out <= miss_cnt_out + 1'b1;
            end
        end else begin
            res_done_out   <= 1'b0;
            mispredict_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msrv32_branch_predict_unit.sv
// Self-checking bench for msrv32_branch_predict_unit.
// Vector table, corner sequences and random resolves vs. a reference model.
module tb_msrv32_branch_predict_unit;

    localparam int XLEN = 32;
    localparam int IDX_BITS = 6;
    localparam int CNT_W = 4;
    localparam int DEPTH = 1 << IDX_BITS;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_out;
    logic             res_valid;
    logic [XLEN-1:0]  res_pc;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [4:0]       opcode;
    logic [2:0]       funct3;
    logic             res_pred;
    logic             done;
    logic             taken;
    logic             misp;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    msrv32_branch_predict_unit #(
        .XLEN(XLEN), .IDX_BITS(IDX_BITS), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .fetch_pc_in(fetch_pc),
        .predict_taken_out(pred_out),
        .res_valid_in(res_valid),
        .res_pc_in(res_pc),
        .rs1_in(rs1),
        .rs2_in(rs2),
        .opcode_in(opcode),
        .funct3_in(funct3),
        .res_pred_in(res_pred),
        .res_done_out(done),
        .branch_taken_out(taken),
        .mispredict_out(misp),
        .branch_cnt_out(br_cnt),
        .miss_cnt_out(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_ctr [DEPTH];
    int m_br;
    int m_miss;
    logic m_taken;

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] b;
        logic       pred;
        logic       exp_taken;
        logic       exp_misp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(logic [31:0] pc);
        return int'(pc[IDX_BITS+1:2]);
    endfunction

    function automatic logic ref_taken(logic [4:0] op, logic [2:0] f3,
                                       logic [31:0] a, logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (op == 5'b11011 || op == 5'b11001) return 1'b1;
        if (op != 5'b11000) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_cond(logic [4:0] op, logic [2:0] f3);
        return op == 5'b11000 && f3 != 3'd2 && f3 != 3'd3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
        m_br = 0;
        m_miss = 0;
        m_taken = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic resolve(string name, logic [31:0] pc, logic [31:0] fpc,
                           logic [4:0] op, logic [2:0] f3,
                           logic [31:0] a, logic [31:0] b, logic pred,
                           output logic o_taken, output logic o_misp);
        logic t;
        int k;
        res_valid = 1'b1;
        res_pc = pc;
        fetch_pc = fpc;
        opcode = op;
        funct3 = f3;
        rs1 = a;
        rs2 = b;
        res_pred = pred;
        #1;
        chk({name, " pre-pred"}, 32'(pred_out), 32'(m_ctr[idx_of(fpc)] >= 2));
        t = ref_taken(op, f3, a, b);
        k = idx_of(pc);
        if (ref_cond(op, f3)) begin
            if (t && m_ctr[k] < 3) m_ctr[k]++;
            if (!t && m_ctr[k] > 0) m_ctr[k]--;
            if (m_br < CMAX) m_br++;
        end
        if ((t ^ pred) && m_miss < CMAX) m_miss++;
        m_taken = t;
        o_taken = t;
        o_misp = t ^ pred;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " taken"}, 32'(taken), 32'(t));
        chk({name, " misp"}, 32'(misp), 32'(t ^ pred));
        chk({name, " br_cnt"}, 32'(br_cnt), 32'(m_br));
        chk({name, " miss_cnt"}, 32'(miss_cnt), 32'(m_miss));
        fetch_pc = pc;
        #1;
        chk({name, " post-pred"}, 32'(pred_out), 32'(m_ctr[k] >= 2));
    endtask

    logic ot, om;

    initial begin
        vecs[0]  = '{"blt", 5'b11000, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{"bltu", 5'b11000, 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"beq", 5'b11000, 3'd0, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{"bne", 5'b11000, 3'd1, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{"bge", 5'b11000, 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"bgeu", 5'b11000, 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{"jal", 5'b11011, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{"jalr", 5'b11001, 3'd3, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{"br010", 5'b11000, 3'd2, 32'd7, 32'd7, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"br011", 5'b11000, 3'd3, 32'd7, 32'd7, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{"alu_p1", 5'b01100, 3'd0, 32'd3, 32'd3, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{"alu_p0", 5'b00100, 3'd0, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        res_valid = 1'b0;
        fetch_pc = '0;
        res_pc = '0;
        rs1 = '0;
        rs2 = '0;
        opcode = '0;
        funct3 = '0;
        res_pred = 1'b0;
        model_reset();
        #2;
        chk("rst done", 32'(done), 32'd0);
        chk("rst taken", 32'(taken), 32'd0);
        chk("rst misp", 32'(misp), 32'd0);
        chk("rst br_cnt", 32'(br_cnt), 32'd0);
        chk("rst miss_cnt", 32'(miss_cnt), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            fetch_pc = 32'(i) << 2;
            #1;
            chk("rst lookup", 32'(pred_out), 32'd0);
        end
        @(posedge clk);
        #1;

        // Vector table at distinct indices 0..11
        for (int i = 0; i < 12; i++) begin
            resolve(vecs[i].name, 32'h200 + 32'(i) * 4, 32'h200 + 32'(i) * 4,
                    vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b,
                    vecs[i].pred, ot, om);
            chk({vecs[i].name, " tbl taken"}, 32'(ot), 32'(vecs[i].exp_taken));
            chk({vecs[i].name, " tbl misp"}, 32'(om), 32'(vecs[i].exp_misp));
            if (i == 0) begin
                chk("blt br_cnt=1", 32'(br_cnt), 32'd1);
                chk("blt miss_cnt=1", 32'(miss_cnt), 32'd1);
            end
        end

        // Idle cycle: done and mispredict drop, taken holds
        @(posedge clk);
        #1;
        chk("idle done", 32'(done), 32'd0);
        chk("idle misp", 32'(misp), 32'd0);
        chk("idle taken hold", 32'(taken), 32'(m_taken));

        // Saturation at 0x40
        for (int i = 0; i < 4; i++) begin
            resolve("sat up", 32'h40, 32'h40, 5'b11000, 3'd0, 32'd5, 32'd5,
                    1'b1, ot, om);
        end
        chk("sat ctr=3", 32'(m_ctr[16]), 32'd3);
        chk("sat pred", 32'(pred_out), 32'd1);
        resolve("sat dn1", 32'h40, 32'h40, 5'b11000, 3'd0, 32'd5, 32'd6,
                1'b1, ot, om);
        chk("sat dn1 pred", 32'(pred_out), 32'd1);
        resolve("sat dn2", 32'h40, 32'h40, 5'b11000, 3'd0, 32'd5, 32'd6,
                1'b1, ot, om);
        resolve("sat dn3", 32'h40, 32'h40, 5'b11000, 3'd0, 32'd5, 32'd6,
                1'b0, ot, om);
        resolve("sat dn4", 32'h40, 32'h40, 5'b11000, 3'd0, 32'd5, 32'd6,
                1'b0, ot, om);
        resolve("sat up0", 32'h40, 32'h40, 5'b11000, 3'd0, 32'd5, 32'd5,
                1'b0, ot, om);
        chk("sat low pred", 32'(pred_out), 32'd0);

        // Same-cycle hazard and aliasing on index 32
        resolve("hazard", 32'h80, 32'h80, 5'b11000, 3'd0, 32'd9, 32'd9,
                1'b0, ot, om);
        chk("hazard next", 32'(pred_out), 32'd1);
        fetch_pc = 32'h180;
        #1;
        chk("alias 0x180", 32'(pred_out), 32'd1);

        // Random resolves
        for (int n = 0; n < 300; n++) begin
            logic [4:0] op;
            logic [31:0] a, b;
            case ($urandom_range(0, 5))
                0: op = 5'b11011;
                1: op = 5'b11001;
                2: op = 5'b01100;
                default: op = 5'b11000;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            resolve("rand", {$urandom_range(0, 3) == 0 ? 32'($urandom) :
                             32'($urandom_range(0, 15)) << 2},
                    32'($urandom), op, 3'($urandom), a, b,
                    1'($urandom), ot, om);
        end
        chk("stat br sat", 32'(br_cnt), 32'(CMAX));

        // Reset in the middle of a resolve
        @(posedge clk);
        #1;
        res_valid = 1'b1;
        res_pc = 32'h80;
        opcode = 5'b11000;
        funct3 = 3'd0;
        rs1 = 32'd1;
        rs2 = 32'd1;
        res_pred = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst taken", 32'(taken), 32'd0);
        chk("midrst br_cnt", 32'(br_cnt), 32'd0);
        chk("midrst miss_cnt", 32'(miss_cnt), 32'd0);
        fetch_pc = 32'h80;
        #1;
        chk("midrst pred", 32'(pred_out), 32'd0);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst done", 32'(done), 32'd0);
        chk("post rst br_cnt", 32'(br_cnt), 32'd0);
        chk("post rst pred", 32'(pred_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
